// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - mode-selectable immediate extension behind a valid/ready register with skid buffer
module imm_extend_pipe #(
  parameter int I_NBITS   = 16,
  parameter int O_NBITS   = 32,
  parameter int BR_SHIFT  = 2,
  parameter int TAG_NBITS = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [I_NBITS-1:0]   i_imm,
  input  logic [1:0]           i_mode,
  input  logic [TAG_NBITS-1:0] i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [O_NBITS-1:0]   o_ext,
  output logic [TAG_NBITS-1:0] o_tag
);

  localparam int PAD = O_NBITS - I_NBITS;
  localparam logic [O_NBITS-1:0] HI_MASK = ~({O_NBITS{1'b1}} >> PAD);

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;

  logic                 main_v, skid_v;
  logic [O_NBITS-1:0]   main_d, skid_d;
  logic [TAG_NBITS-1:0] main_t, skid_t;

  logic [O_NBITS-1:0] zext, sext, ext_new;
  logic               accept, load_main;

  always_comb begin
    zext = O_NBITS'(i_imm);
    sext = zext | (i_imm[I_NBITS-1] ? HI_MASK : '0);
    case (i_mode)
      MODE_SIGN:  ext_new = sext;
      MODE_ZERO:  ext_new = zext;
      MODE_UPPER: ext_new = zext << PAD;
      default:    ext_new = sext << BR_SHIFT;
    endcase
  end

  // o_ready comes straight from a flop, so upstream never sees i_ready combinationally
  assign o_ready   = ~skid_v;
  assign accept    = i_valid & o_ready;
  assign load_main = ~main_v | i_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      main_v <= 1'b0;
      main_d <= '0;
      main_t <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
      skid_t <= '0;
    end else if (i_flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (load_main) begin
      if (skid_v) begin
        main_v <= 1'b1;
        main_d <= skid_d;
        main_t <= skid_t;
        skid_v <= 1'b0;
      end else if (accept) begin
        main_v <= 1'b1;
        main_d <= ext_new;
        main_t <= i_tag;
      end else begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      skid_v <= 1'b1;
      skid_d <= ext_new;
      skid_t <= i_tag;
    end
  end

  assign o_valid = main_v;
  assign o_ext   = main_d;
  assign o_tag   = main_t;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic        o_ready, o_valid;
  logic [15:0] imm;
  logic [1:0]  mode;
  logic [4:0]  tag;
  logic [31:0] o_ext;
  logic [4:0]  o_tag;

  logic        p_valid, p_oready, p_ovalid;
  logic [11:0] p_imm;
  logic [1:0]  p_mode;
  logic [4:0]  p_tag, p_otag;
  logic [15:0] p_ext;

  int checks = 0;
  int errors = 0;

  imm_extend_pipe dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_valid(in_valid), .o_ready(o_ready), .i_imm(imm), .i_mode(mode), .i_tag(tag),
    .o_valid(o_valid), .i_ready(out_ready), .o_ext(o_ext), .o_tag(o_tag)
  );

  imm_extend_pipe #(.I_NBITS(12), .O_NBITS(16), .BR_SHIFT(1), .TAG_NBITS(5)) dut_small (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(1'b0),
    .i_valid(p_valid), .o_ready(p_oready), .i_imm(p_imm), .i_mode(p_mode), .i_tag(p_tag),
    .o_valid(p_ovalid), .i_ready(1'b1), .o_ext(p_ext), .o_tag(p_otag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m, input logic [4:0] t);
    in_valid = v;
    imm      = d;
    mode     = m;
    tag      = t;
  endtask

  // Outputs must not move while stalled (flush and reset excepted)
  logic        hold_q = 1'b0;
  logic [31:0] hold_ext;
  logic [4:0]  hold_tag;
  always @(negedge clk) begin
    if (rst_n && hold_q) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_ext", o_ext, hold_ext);
      check("hold_tag", 32'(o_tag), 32'(hold_tag));
    end
    hold_q   = o_valid & ~out_ready & ~flush & rst_n;
    hold_ext = o_ext;
    hold_tag = o_tag;
  end

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h8001, 2'b00, 32'hFFFF8001};
    vecs[1] = '{16'h8001, 2'b01, 32'h00008001};
    vecs[2] = '{16'h1234, 2'b10, 32'h12340000};
    vecs[3] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
    vecs[4] = '{16'h0010, 2'b11, 32'h00000040};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, 2'b00, '0);
    p_valid = 1'b0; p_imm = '0; p_mode = '0; p_tag = '0;
    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_ext", o_ext, 32'd0);
    check("rst_tag", 32'(o_tag), 32'd0);
    #1 rst_n = 1'b1;

    // Extension modes, one result per cycle
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, vecs[k].d, vecs[k].m, 5'(k + 1));
      tick();
      check("mode_valid", 32'(o_valid), 32'd1);
      check("mode_ext", o_ext, vecs[k].exp);
      check("mode_tag", 32'(o_tag), 32'(k + 1));
    end
    drive(1'b0, '0, 2'b00, '0);
    tick();
    check("mode_drain", 32'(o_valid), 32'd0);

    // Backpressure: tags 1,2,3 with 3 stalled cycles
    out_ready = 1'b0;
    drive(1'b1, 16'd1, 2'b01, 5'd1);
    tick();
    check("bp_ready1", 32'(o_ready), 32'd1);
    check("bp_tag1", 32'(o_tag), 32'd1);
    drive(1'b1, 16'd2, 2'b01, 5'd2);
    tick();
    check("bp_ready_skid", 32'(o_ready), 32'd0);
    check("bp_hold1", 32'(o_tag), 32'd1);
    drive(1'b1, 16'd3, 2'b01, 5'd3);
    tick();
    check("bp_ready_full", 32'(o_ready), 32'd0);
    check("bp_hold1b", 32'(o_tag), 32'd1);
    tick();
    check("bp_hold1c", o_ext, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_out2", 32'(o_tag), 32'd2);
    check("bp_out2_ext", o_ext, 32'd2);
    check("bp_ready_back", 32'(o_ready), 32'd1);
    tick();
    check("bp_out3", 32'(o_tag), 32'd3);
    check("bp_out3_v", 32'(o_valid), 32'd1);
    drive(1'b0, '0, 2'b00, '0);
    tick();
    check("bp_drain", 32'(o_valid), 32'd0);

    // Full-rate streaming
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 16'h0100 + 16'(k), 2'b01, 5'(10 + k));
      tick();
      check("tp_ready", 32'(o_ready), 32'd1);
      check("tp_valid", 32'(o_valid), 32'd1);
      check("tp_tag", 32'(o_tag), 32'(10 + k));
      check("tp_ext", o_ext, 32'h0100 + 32'(k));
    end
    drive(1'b0, '0, 2'b00, '0);
    tick();
    check("tp_drain", 32'(o_valid), 32'd0);

    // Flush with main and skid full
    out_ready = 1'b0;
    drive(1'b1, 16'd20, 2'b01, 5'd20);
    tick();
    drive(1'b1, 16'd21, 2'b01, 5'd21);
    tick();
    check("fl_full", 32'(o_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 16'd22, 2'b01, 5'd22);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 2'b00, '0);
    check("fl_valid", 32'(o_valid), 32'd0);
    check("fl_ready", 32'(o_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    check("fl_gone", 32'(o_valid), 32'd0);

    // Flush drops an operand that would otherwise be accepted
    out_ready = 1'b0;
    drive(1'b1, 16'd23, 2'b01, 5'd23);
    tick();
    flush = 1'b1;
    drive(1'b1, 16'd24, 2'b01, 5'd24);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 2'b00, '0);
    out_ready = 1'b1;
    check("fl2_valid", 32'(o_valid), 32'd0);
    tick();
    check("fl2_gone", 32'(o_valid), 32'd0);

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(1'b1, 16'd30, 2'b01, 5'd30);
    tick();
    drive(1'b1, 16'd31, 2'b01, 5'd31);
    tick();
    drive(1'b0, '0, 2'b00, '0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(o_valid), 32'd0);
    check("ar_ext", o_ext, 32'd0);
    check("ar_ready", 32'(o_ready), 32'd1);
    check("ar_tag", 32'(o_tag), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h7FFF, 2'b00, 5'd5);
    tick();
    check("ar_first_v", 32'(o_valid), 32'd1);
    check("ar_first_ext", o_ext, 32'h00007FFF);
    check("ar_first_tag", 32'(o_tag), 32'd5);
    drive(1'b0, '0, 2'b00, '0);

    // Narrow instance: I=12, O=16, BR_SHIFT=1
    p_valid = 1'b1; p_imm = 12'h800; p_mode = 2'b00; p_tag = 5'd7;
    tick();
    check("p_sign", 32'(p_ext), 32'h0000F800);
    check("p_tag", 32'(p_otag), 32'd7);
    p_mode = 2'b11;
    tick();
    check("p_branch", 32'(p_ext), 32'h0000F000);
    p_imm = 12'hABC; p_mode = 2'b10;
    tick();
    check("p_upper", 32'(p_ext), 32'h0000ABC0);
    check("p_valid", 32'(p_ovalid), 32'd1);
    p_valid = 1'b0;
    tick();
    check("p_drain", 32'(p_ovalid), 32'd0);
    check("p_ready", 32'(p_oready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Registered, mode-selectable immediate-extension stage for the ID→EX path. It widens an I_NBITS immediate to O_NBITS in one of four modes: sign, zero, upper-load, or branch-offset. The result passes through a valid/ready pipeline register backed by a one-entry skid buffer, so downstream stalls never drop or reorder operands. A flush input discards in-flight entries on branch mispredict.

Parameters:
I_NBITS, 16, immediate input width
O_NBITS, 32, extended output width; must satisfy O_NBITS >= I_NBITS + BR_SHIFT
BR_SHIFT, 2, left shift applied in branch-offset mode
TAG_NBITS, 5, width of the sideband tag carried with each operand (e.g. destination register)

Ports:
i_clock  in  1  rising-edge clock
i_reset_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous flush; clears all in-flight entries
i_valid  in  1  upstream operand valid
o_ready  out  1  block can accept an operand this cycle
i_imm  in  I_NBITS  raw immediate
i_mode  in  2  00 sign, 01 zero, 10 upper, 11 branch
i_tag  in  TAG_NBITS  sideband tag, passed through unchanged
o_valid  out  1  output entry valid
i_ready  in  1  downstream accepts the output
o_ext  out  O_NBITS  extended immediate
o_tag  out  TAG_NBITS  tag matching o_ext

Behaviour:
- Extension (combinational, evaluated on accept):
  - sign: replicate i_imm[I_NBITS-1] into the upper O_NBITS-I_NBITS bits.
  - zero: zero-fill the upper bits.
  - upper: i_imm placed at bits [O_NBITS-1 : O_NBITS-I_NBITS]; lower bits are 0.
  - branch: sign-extend, then shift left by BR_SHIFT. Bits shifted out are discarded; the LSBs are 0.
- Storage: main register (main_v, main_d, main_t) drives the outputs directly. Skid register (skid_v, skid_d, skid_t) is internal.
- o_ready = ~skid_v. It is a registered value with no combinational path from i_ready.
- Accept = i_valid & o_ready. Handshake out = o_valid & i_ready.
- Latency: an operand accepted at edge N appears on o_ext/o_valid after edge N, i.e. one cycle, when no stall is present.
- Each clock edge, in priority order:
  1. i_flush = 1: main_v ← 0, skid_v ← 0. Any accept in that cycle is discarded. Data registers hold their value.
  2. main empty, or main handshaking out: main ← skid if skid_v, else main ← new operand if accept, else main_v ← 0. skid_v ← 0 when skid moves to main.
  3. main full and i_ready = 0: an accepted operand goes to skid (skid_v ← 1).
- Ordering: strictly FIFO. The skid entry always leaves before any newer operand.
- Simultaneous handshake out and accept with skid empty: the new operand goes straight into main; o_valid stays 1.
- Full state (main_v & skid_v): o_ready = 0. Any i_valid is ignored and must be held by upstream.
- o_valid, o_ext, and o_tag must stay stable while o_valid & ~i_ready. The bench asserts this.
- Reset (asynchronous, any time including mid-stall): main_v = skid_v = 0, o_valid = 0, o_ready = 1, o_ext = 0, o_tag = 0, skid data = 0. First accept is possible on the first edge after deassertion.
- No other state. The ready/valid logic is independent of the parameters.

Test Plan:
- Modes (I=16, O=32, i_ready=1): 0x8001/sign → 0xFFFF8001; 0x8001/zero → 0x00008001; 0x1234/upper → 0x12340000; 0xFFFF/branch → 0xFFFFFFFC; 0x0010/branch → 0x00000040. Each result appears one cycle after accept, with the tag intact.
- Backpressure: stream tags 1,2,3 back-to-back while i_ready=0 for 3 cycles.
  - o_ready drops after tag 2 enters skid; tag 3 is held by upstream.
  - Output holds tag 1 stable.
  - On release, outputs 1,2,3 emerge in order with no duplicates.
- Simultaneous in/out: continuous i_valid=1 and i_ready=1 for 8 operands → throughput of 1 per cycle; o_ready never deasserts.
- Flush: fill main and skid, then pulse i_flush together with i_valid=1.
  - Next cycle: o_valid=0 and o_ready=1; the flushed-cycle operand never appears.
- Reset mid-operation: assert i_reset_n=0 asynchronously between edges while the block is full.
  - Outputs immediately go to o_valid=0, o_ext=0, o_ready=1.
  - After release, 0x7FFF/sign → 0x00007FFF.
- Parameter sweep: I=12, O=16, BR_SHIFT=1: 0x800/sign → 0xF800; 0x800/branch → 0xF000; 0xABC/upper → 0xABC0.
